// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - shared types and constants for the MEM-stage data-memory responder
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_RDONE = 2'd3
    } state_t;

    localparam int WB_DEPTH_DEF = 4;
    localparam int WORD_AW      = 30;

endpackage

// File: rtl/pipe_wbuf.sv
// rtl/pipe_wbuf.sv - circular store queue with youngest-match load forwarding
module pipe_wbuf
    import pipe_mem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF,
    parameter int AW    = WORD_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enq,
    input  logic [AW-1:0] enq_addr,
    input  logic [31:0]   enq_data,
    input  logic          deq,
    input  logic [AW-1:0] lookup_addr,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [31:0]   head_data,
    output logic          hit,
    output logic [31:0]   hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] idx;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (enq) begin
            addr_d[tail_q] = enq_addr;
            data_d[tail_q] = enq_data;
            tail_d         = tail_q + PW'(1);
        end
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match left standing is the youngest copy.
    always_comb begin
        hit      = 1'b0;
        hit_data = 32'd0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];

endmodule

// File: rtl/pipe_dmem_responder.sv
// rtl/pipe_dmem_responder.sv - MEM-stage responder: write buffer, drain/refill FSM, stall and load response
module pipe_dmem_responder
    import pipe_mem_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEF,
    parameter int AW       = WORD_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic [31:0]   rdata,
    output logic          rvalid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   hold_q, hold_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [AW-1:0] word_addr;
    logic [1:0]    unused_addr_bits;
    logic          wb_full, wb_empty, wb_hit, load_miss;
    logic [AW-1:0] head_addr;
    logic [31:0]   head_data, hit_data;

    assign word_addr        = addr[AW+1:2];
    assign unused_addr_bits = addr[1:0];

    pipe_wbuf #(.DEPTH(WB_DEPTH), .AW(AW)) u_wbuf (
        .clock       (clock),
        .reset       (reset),
        .enq         (req & we & ~wb_full),
        .enq_addr    (word_addr),
        .enq_data    (wdata),
        .deq         ((state_q == ST_WR) & mem_ack),
        .lookup_addr (word_addr),
        .full        (wb_full),
        .empty       (wb_empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .hit         (wb_hit),
        .hit_data    (hit_data)
    );

    assign load_miss = req & ~we & ~wb_hit;
    assign stall     = req & (we ? wb_full : ~(wb_hit | (state_q == ST_RDONE)));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        rvalid_d    = req & ~we & ~stall;
        rdata_d     = rdata_q;
        if (rvalid_d) begin
            rdata_d = wb_hit ? hit_data : hold_q;
        end
        // Acks are only honoured in WR/RD, so a stale ack after reset lands in IDLE and is dropped.
        case (state_q)
            ST_IDLE: begin
                if (load_miss) begin
                    state_d    = ST_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = word_addr;
                end else if (!wb_empty) begin
                    state_d     = ST_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_d   = ST_RDONE;
                    mem_req_d = 1'b0;
                    hold_d    = mem_rdata;
                end
            end
            ST_RDONE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_q      <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// tb/tb_pipe_dmem_responder.sv - self-checking bench with a store-queue/memory model
module tb_pipe_dmem_responder;

    localparam int WB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        stall, rvalid;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    pipe_dmem_responder #(.WB_DEPTH(WB), .AW(30)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        wbq[$];
    logic [31:0] memarr [logic [29:0]];
    logic [29:0] wlog[$];
    logic        oplog[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_reads = 0;
    int          mem_lat = 2;

    logic        exp_rv = 1'b0, miss_ready = 1'b0, prev_miss = 1'b0;
    logic [31:0] exp_rd = 32'd0, miss_data = 32'd0;
    logic        busy = 1'b0, drop_chk = 1'b0, stale_ack_req = 1'b0;
    int          cnt = 0;
    logic        cap_we;
    logic [29:0] cap_addr;
    logic [31:0] cap_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [29:0] a);
        if (memarr.exists(a)) return memarr[a];
        return {a, 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic hitf(input logic [29:0] a, output logic [31:0] d);
        logic h = 1'b0;
        d = 32'd0;
        foreach (wbq[i]) begin
            if (wbq[i].a == a) begin
                h = 1'b1;
                d = wbq[i].d;
            end
        end
        return h;
    endfunction

    // Model + memory responder: runs on the falling edge, predicts the next rising edge.
    always @(negedge clock) begin
        logic [29:0] wa;
        logic        h, es, miss_now, rd_ack;
        logic [31:0] hd;
        if (reset) begin
            wbq.delete();
            exp_rv     = 1'b0;
            miss_ready = 1'b0;
            prev_miss  = 1'b0;
            busy       = 1'b0;
            drop_chk   = 1'b0;
            mem_ack    = 1'b0;
        end else begin
            wa = addr[31:2];
            rd_ack = 1'b0;
            check("rvalid", rvalid, exp_rv);
            if (exp_rv) check("rdata", rdata, exp_rd);
            h  = hitf(wa, hd);
            es = req & (we ? (wbq.size() == WB) : !(h | miss_ready));
            check("stall", stall, es);
            miss_now = req & !we & !h & !miss_ready;
            mem_ack = 1'b0;
            if (drop_chk) check("mem_drop", mem_req, 1'b0);
            drop_chk = 1'b0;
            if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    cap_we = mem_we;
                    cap_addr = mem_addr;
                    cap_wdata = mem_wdata;
                    oplog.push_back(mem_we);
                    if (prev_miss && miss_now) check("rd_before_drain", mem_we, 1'b0);
                end else begin
                    check("mem_stable_we", mem_we, cap_we);
                    check("mem_stable_addr", mem_addr, cap_addr);
                    if (cap_we) check("mem_stable_wdata", mem_wdata, cap_wdata);
                end
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ack  = 1'b1;
                    busy     = 1'b0;
                    drop_chk = 1'b1;
                    if (cap_we) begin
                        check("wr_queue_nonempty", wbq.size() != 0, 1'b1);
                        if (wbq.size() != 0) begin
                            check("wr_addr", cap_addr, wbq[0].a);
                            check("wr_data", cap_wdata, wbq[0].d);
                            void'(wbq.pop_front());
                        end
                        memarr[cap_addr] = cap_wdata;
                        wlog.push_back(cap_addr);
                    end else begin
                        check("rd_has_load", miss_now, 1'b1);
                        if (miss_now) check("rd_addr", cap_addr, wa);
                        mem_rdata = memval(cap_addr);
                        miss_data = mem_rdata;
                        rd_ack    = 1'b1;
                        n_reads++;
                    end
                end
            end else if (stale_ack_req) begin
                mem_ack       = 1'b1;
                mem_rdata     = 32'hBAD0_BAD0;
                stale_ack_req = 1'b0;
            end
            exp_rv = req & !we & !es;
            if (exp_rv) begin
                exp_rd = h ? hd : miss_data;
                if (!h) miss_ready = 1'b0;
            end
            if (req & we & !es) wbq.push_back('{a: wa, d: wdata});
            if (rd_ack) miss_ready = 1'b1;
            prev_miss = miss_now;
        end
    end

    // Presents one request, holds it through stall, returns just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int stalls);
        req = 1'b1; we = w; addr = a; wdata = d;
        stalls = 0;
        forever begin
            @(negedge clock);
            if (!stall || stalls >= 200) break;
            stalls++;
        end
        if (stalls >= 200) check("issue_timeout", 32'(stalls), 32'd0);
        @(posedge clock); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp, input int exp_stalls);
        int s;
        issue(1'b0, a, 32'd0, s);
        if (exp_stalls >= 0) check({name, "_stalls"}, 32'(s), 32'(exp_stalls));
        @(negedge clock);
        check({name, "_rvalid"}, rvalid, 1'b1);
        check({name, "_rdata"}, rdata, exp);
        @(posedge clock); #1;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 2 && n < 300) begin
            @(negedge clock);
            n++;
            if (!mem_req && !busy && wbq.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 2) check("idle_timeout", 32'(n), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int s, r0;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        memarr[30'h80] = 32'hDEAD_BEEF;
        #2;
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 30'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        req = 1'b1; we = 1'b1; #1;
        check("rst_stall_store", stall, 1'b0);
        we = 1'b0; #1;
        check("rst_stall_loadmiss", stall, 1'b1);
        req = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // store then immediate load hit
        r0 = n_reads;
        issue(1'b1, 32'h100, 32'hA5A5_A5A5, s);
        load_check("fwd", 32'h103, 32'hA5A5_A5A5, 0);
        wait_idle();
        check("fwd_no_read", 32'(n_reads), 32'(r0));

        // youngest copy wins
        issue(1'b1, 32'h10, 32'd1, s);
        issue(1'b1, 32'h10, 32'd2, s);
        load_check("youngest", 32'h10, 32'd2, 0);
        wait_idle();

        // five back-to-back stores into a four-deep buffer
        mem_lat = 3;
        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 32'h20 + 32'(4 * i), 32'h11 + 32'(i), s);
            if (i == 4) check("fifth_store_stalled", 32'(s != 0), 32'd1);
            else check("store_no_stall", 32'(s), 32'd0);
        end
        wait_idle();
        check("wlog_len", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check("wlog_order", 32'(wlog[i]), 32'h8 + 32'(i));

        // load miss with memory returning after two cycles
        mem_lat = 2;
        load_check("miss", 32'h200, 32'hDEAD_BEEF, 3);
        wait_idle();

        // load miss arriving while a drain is in flight
        mem_lat = 4;
        oplog.delete();
        issue(1'b1, 32'h40, 32'd7, s);
        issue(1'b1, 32'h44, 32'd8, s);
        load_check("miss_drain", 32'h500, 32'h5A5A_0500, -1);
        wait_idle();
        check("op_count", 32'(oplog.size()), 32'd3);
        if (oplog.size() == 3) begin
            check("op0_write", oplog[0], 1'b1);
            check("op1_read", oplog[1], 1'b0);
            check("op2_write", oplog[2], 1'b1);
        end

        // reset while a read is outstanding with three stores buffered
        mem_lat = 8;
        for (int i = 0; i < 4; i++) issue(1'b1, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i), s);
        req = 1'b1; we = 1'b0; addr = 32'h300;
        s = 0;
        while (!(mem_req && !mem_we) && s < 80) begin
            @(negedge clock);
            s++;
        end
        check("reached_rd", 32'(mem_req && !mem_we), 32'd1);
        @(posedge clock); #3;
        reset = 1'b1; req = 1'b0;
        #1;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_mem_we", mem_we, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 30'd0);
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        @(negedge clock); #1;
        reset = 1'b0;
        stale_ack_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("post_rst_idle", mem_req, 1'b0);
        end
        @(posedge clock); #1;
        mem_lat = 2;
        load_check("discarded", 32'h404, 32'h5A5A_0404, 3);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
